// File: rtl/limb_wb_bridge_if.sv
// limb_wb_bridge_if: LIMB pad signals plus the Wishbone master bus of the bridge.
//   master : the bridge (drives limb_d_out/oe/nwait and the wb_*_o signals)
//   slave  : the environment (EC pad logic and the Wishbone interconnect)
interface limb_wb_bridge_if #(
  parameter int ADDR_W     = 36,
  parameter int DATA_BYTES = 4
);
  localparam int DW = 8 * DATA_BYTES;

  logic [7:0]            limb_d_in;
  logic [7:0]            limb_d_out;
  logic                  limb_d_oe;
  logic                  limb_clk;
  logic                  limb_nrd;
  logic                  limb_start;
  logic                  limb_nwait;
  logic [ADDR_W-1:0]     wb_adr_o;
  logic                  wb_we_o;
  logic [DATA_BYTES-1:0] wb_sel_o;
  logic                  wb_stb_o;
  logic                  wb_cyc_o;
  logic [DW-1:0]         wb_dat_o;
  logic [DW-1:0]         wb_dat_i;
  logic                  wb_ack_i;
  logic                  wb_err_o;

  modport master (
    input  limb_d_in, limb_clk, limb_nrd, limb_start, wb_dat_i, wb_ack_i,
    output limb_d_out, limb_d_oe, limb_nwait,
    output wb_adr_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o, wb_dat_o, wb_err_o
  );

  modport slave (
    output limb_d_in, limb_clk, limb_nrd, limb_start, wb_dat_i, wb_ack_i,
    input  limb_d_out, limb_d_oe, limb_nwait,
    input  wb_adr_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o, wb_dat_o, wb_err_o
  );
endinterface

// File: rtl/limb_wb_bridge.sv
// limb_wb_bridge: LIMB(EC) byte bus to Wishbone master bridge.
// Oversamples the LIMB strobe in the clk domain, assembles little-endian
// address/data words, runs one Wishbone cycle at a time and stalls the EC
// via limb_nwait until each cycle ends. Address autoincrements (full width)
// after every completed cycle for block transfers.
// Ports:
//   clk, reset : system clock, asynchronous active-high reset
//   bus        : limb_wb_bridge_if.master (LIMB pad signals + Wishbone master)
// Optional feature macro: LIMB_WB_TIMEOUT_EN -- ack watchdog of TIMEOUT_CYCLES;
//   on expiry the cycle is ended, wb_err_o is set and reads return all ones.
module limb_wb_bridge #(
  parameter int ADDR_W         = 36,
  parameter int DATA_BYTES     = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input logic               clk,
  input logic               reset,
  limb_wb_bridge_if.master  bus
);
  localparam int AB   = (ADDR_W + 7) / 8;
  localparam int DW   = 8 * DATA_BYTES;
  localparam int BMAX = (AB > DATA_BYTES) ? AB : DATA_BYTES;
  localparam int BCW  = (BMAX > 1) ? $clog2(BMAX) : 1;
  localparam int SW   = 11;   // {limb_clk, limb_start, limb_nrd, limb_d_in}

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("limb_wb_bridge: SYNC_STAGES must be 2..4");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_tmo
    $error("limb_wb_bridge: TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WDATA, S_WBW, S_WBR, S_RDATA} state_t;

  state_t            state;
  logic [BCW-1:0]    bcnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DW-1:0]     wdata_q;
  logic [DW-1:0]     rbuf_q;
  logic              cyc_q, we_q, nwait_q, err_q;
  logic              tmo;

  // All LIMB inputs share one chain so data/start/nrd line up with the strobe.
  logic [SYNC_STAGES-1:0][SW-1:0] sync_q;
  logic                           lclk_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q    <= '0;
      lclk_prev <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0],
                    {bus.limb_clk, bus.limb_start, bus.limb_nrd, bus.limb_d_in}};
      lclk_prev <= sync_q[SYNC_STAGES-1][10];
    end
  end

  logic [SW-1:0] s;
  logic [7:0]    s_d;
  logic          s_start, s_nrd, evt, start_evt, ev_ok, done, cyc_out;

  assign s         = sync_q[SYNC_STAGES-1];
  assign s_start   = s[9];
  assign s_nrd     = s[8];
  assign s_d       = s[7:0];
  assign evt       = s[10] & ~lclk_prev;
  assign start_evt = evt & s_start;
  // Events arriving while the EC is told to wait are protocol violations.
  assign ev_ok     = evt & ~s_start & nwait_q;
  assign done      = cyc_q & (bus.wb_ack_i | tmo);

  // Byte merge; the address is widened to whole bytes so the top byte's
  // excess bits fall off when truncated back to ADDR_W.
  logic [AB*8-1:0]   addr_pad;
  logic [ADDR_W-1:0] addr_ld;
  logic [DW-1:0]     wdata_ld;

  always_comb begin
    addr_pad = '0;
    addr_pad[ADDR_W-1:0] = addr_q;
    addr_pad[(start_evt ? 0 : int'(bcnt)) * 8 +: 8] = s_d;
    addr_ld  = addr_pad[ADDR_W-1:0];
    wdata_ld = wdata_q;
    wdata_ld[int'(bcnt) * 8 +: 8] = s_d;
  end

`ifdef LIMB_WB_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TCW-1:0] tcnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                    tcnt <= '0;
    else if (!cyc_q || start_evt || bus.wb_ack_i) tcnt <= '0;
    else                                          tcnt <= tcnt + 1'b1;
  end

  assign tmo = cyc_q & ~bus.wb_ack_i & (tcnt == TCW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      bcnt    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rbuf_q  <= '0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      nwait_q <= 1'b1;
      err_q   <= 1'b0;
    end else if (start_evt) begin
      // Start wins everywhere: kills any cycle in flight and restarts.
      addr_q  <= addr_ld;
      bcnt    <= BCW'(1);
      state   <= S_ADDR;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      nwait_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      if (evt && !nwait_q) err_q <= 1'b1;
      if (tmo)             err_q <= 1'b1;
      case (state)
        S_ADDR: if (ev_ok) begin
          addr_q <= addr_ld;
          if (bcnt == BCW'(AB - 1)) begin
            bcnt <= '0;
            if (s_nrd) begin
              state <= S_WDATA;
            end else begin
              state   <= S_WBR;
              cyc_q   <= 1'b1;
              nwait_q <= 1'b0;
            end
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
        S_WDATA: if (ev_ok) begin
          wdata_q <= wdata_ld;
          if (bcnt == BCW'(DATA_BYTES - 1)) begin
            state   <= S_WBW;
            cyc_q   <= 1'b1;
            we_q    <= 1'b1;
            nwait_q <= 1'b0;
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
        S_WBW: if (done) begin
          cyc_q   <= 1'b0;
          we_q    <= 1'b0;
          addr_q  <= addr_q + 1'b1;
          nwait_q <= 1'b1;
          bcnt    <= '0;
          state   <= S_WDATA;
        end
        S_WBR: if (done) begin
          rbuf_q  <= tmo ? '1 : bus.wb_dat_i;
          cyc_q   <= 1'b0;
          addr_q  <= addr_q + 1'b1;
          nwait_q <= 1'b1;
          bcnt    <= '0;
          state   <= S_RDATA;
        end
        S_RDATA: if (ev_ok) begin
          if (bcnt == BCW'(DATA_BYTES - 1)) begin
            // Last byte consumed: prefetch the next word.
            bcnt    <= '0;
            state   <= S_WBR;
            cyc_q   <= 1'b1;
            nwait_q <= 1'b0;
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Gating with start_evt drops the strobe in the same clk the abort is seen.
  assign cyc_out        = cyc_q & ~start_evt;
  assign bus.wb_cyc_o   = cyc_out;
  assign bus.wb_stb_o   = cyc_out;
  assign bus.wb_we_o    = we_q & ~start_evt;
  assign bus.wb_sel_o   = {DATA_BYTES{cyc_out}};
  assign bus.wb_adr_o   = addr_q;
  assign bus.wb_dat_o   = wdata_q;
  assign bus.wb_err_o   = err_q;
  assign bus.limb_nwait = nwait_q;
  assign bus.limb_d_oe  = (state == S_RDATA) || (state == S_WBR);
  assign bus.limb_d_out = (state == S_RDATA) ? rbuf_q[int'(bcnt) * 8 +: 8] : 8'h00;
endmodule

// File: tb/tb_limb_wb_bridge.sv
// tb_limb_wb_bridge: scoreboard bench for limb_wb_bridge. Stimulus pushes the
// expected Wishbone cycles and read bytes; a negedge monitor pops and compares
// whenever the DUT starts a cycle or the EC samples read data.
module tb_limb_wb_bridge;
  localparam int ADDR_W = 36;
  localparam int DB     = 4;
  localparam int DW     = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  limb_wb_bridge_if #(.ADDR_W(ADDR_W), .DATA_BYTES(DB)) bus ();

  limb_wb_bridge #(
    .ADDR_W(ADDR_W), .DATA_BYTES(DB), .SYNC_STAGES(2), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] adr;
    logic [DW-1:0]     dat;
  } wb_exp_t;

  wb_exp_t    wb_q[$];
  logic [7:0] rd_q[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Wishbone slave: ack after ws wait states, never if no_ack.
  int         ws = 0;
  bit         no_ack = 0;
  int         scnt = 0;
  logic       ack = 1'b0;
  logic [31:0] rdata = 32'h0;
  assign bus.wb_ack_i = ack;
  assign bus.wb_dat_i = rdata;

  always @(negedge clk) begin
    if (ack) begin
      ack  = 1'b0;
      scnt = 0;
    end else if (bus.wb_cyc_o) begin
      scnt++;
      if (scnt > ws && !no_ack) ack = 1'b1;
    end else begin
      scnt = 0;
    end
  end

  // Monitor
  logic    cyc_prev = 1'b0;
  logic    rd_sample = 1'b0;
  int      low_run = 0, last_low_run = 0;
  int      cyc_run = 0, last_cyc_run = 0;
  wb_exp_t e;
  logic [7:0] eb;

  always @(negedge clk) begin
    if (bus.wb_cyc_o && !cyc_prev) begin
      if (wb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL wb_unexpected_cycle: got cycle at adr %0h, expected none", bus.wb_adr_o);
      end else begin
        e = wb_q.pop_front();
        chk("wb_adr", bus.wb_adr_o, e.adr);
        chk("wb_we", bus.wb_we_o, e.we);
        chk("wb_stb", bus.wb_stb_o, 1);
        chk("wb_sel", bus.wb_sel_o, 4'hF);
        chk("nwait_low_in_cycle", bus.limb_nwait, 0);
        if (e.we) chk("wb_dat", bus.wb_dat_o, e.dat);
      end
    end
    cyc_prev = bus.wb_cyc_o;
    if (bus.wb_cyc_o) cyc_run++;
    else if (cyc_run > 0) begin last_cyc_run = cyc_run; cyc_run = 0; end
    if (!bus.limb_nwait) low_run++;
    else if (low_run > 0) begin last_low_run = low_run; low_run = 0; end
    if (rd_sample) begin
      if (rd_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rd_unexpected: got d_out %0h, expected no sample", bus.limb_d_out);
      end else begin
        eb = rd_q.pop_front();
        chk("rd_byte", bus.limb_d_out, eb);
        chk("rd_oe", bus.limb_d_oe, 1);
      end
    end
  end

  // EC driver
  task automatic wait_nwait();
    int n = 0;
    while (bus.limb_nwait !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      tests++;
      fails++;
      $display("FAIL nwait_timeout: nwait %b, expected 1 within 200 clk", bus.limb_nwait);
    end
  endtask

  task automatic strobe(logic [7:0] d, logic st, logic nrd, bit honour_wait);
    if (honour_wait) wait_nwait();
    bus.limb_d_in  = d;
    bus.limb_start = st;
    bus.limb_nrd   = nrd;
    repeat (2) @(posedge clk); #1;
    bus.limb_clk = 1'b1;
    repeat (4) @(posedge clk); #1;
    bus.limb_clk = 1'b0;
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic send_addr(logic [39:0] a, logic nrd);
    for (int i = 0; i < 5; i++) strobe(a[i*8 +: 8], (i == 0), nrd, 1);
  endtask

  task automatic send_word(logic [31:0] w);
    for (int i = 0; i < 4; i++) strobe(w[i*8 +: 8], 1'b0, 1'b1, 1);
  endtask

  task automatic read_byte(logic [7:0] exp);
    wait_nwait();
    rd_q.push_back(exp);
    rd_sample = 1'b1;
    @(posedge clk); #1;
    rd_sample = 1'b0;
    strobe(8'h00, 1'b0, 1'b0, 1);
  endtask

  task automatic drain(string name);
    wait_nwait();
    repeat (6) @(posedge clk); #1;
    chk(name, wb_q.size(), 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.limb_clk   = 1'b0;
    bus.limb_start = 1'b0;
    bus.limb_nrd   = 1'b1;
    bus.limb_d_in  = 8'h00;
    reset = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("rst_nwait", bus.limb_nwait, 1);
    chk("rst_cyc", bus.wb_cyc_o, 0);
    chk("rst_stb", bus.wb_stb_o, 0);
    chk("rst_we", bus.wb_we_o, 0);
    chk("rst_sel", bus.wb_sel_o, 0);
    chk("rst_oe", bus.limb_d_oe, 0);
    chk("rst_dout", bus.limb_d_out, 0);
    chk("rst_err", bus.wb_err_o, 0);
    chk("rst_adr", bus.wb_adr_o, 0);
    reset = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Single write then block continuation.
    wb_q.push_back('{1'b1, 36'h876543210, 32'hDEADBEEF});
    wb_q.push_back('{1'b1, 36'h876543211, 32'h03020100});
    wb_q.push_back('{1'b1, 36'h876543212, 32'h07060504});
    wb_q.push_back('{1'b1, 36'h876543213, 32'h0B0A0908});
    send_addr(40'h0876543210, 1'b1);
    send_word(32'hDEADBEEF);
    send_word(32'h03020100);
    send_word(32'h07060504);
    send_word(32'h0B0A0908);
    drain("wb_q_drained_write");

    // Read with 3 wait states, then prefetch at the next address.
    ws = 3;
    rdata = 32'h11223344;
    wb_q.push_back('{1'b0, 36'h000000FFF, 32'h0});
    wb_q.push_back('{1'b0, 36'h000001000, 32'h0});
    send_addr(40'h0000000FFF, 1'b0);
    read_byte(8'h44);
    read_byte(8'h33);
    read_byte(8'h22);
    read_byte(8'h11);
    drain("wb_q_drained_read");
    chk("nwait_low_ge3", (last_low_run >= 3), 1);
    chk("rd_q_drained", rd_q.size(), 0);

    // Wrap: top address byte 0xFF keeps only its low 4 bits.
    ws = 0;
    wb_q.push_back('{1'b1, 36'hFFFFFFFFF, 32'hA5A5A5A5});
    wb_q.push_back('{1'b1, 36'h000000000, 32'h5A5A5A5A});
    send_addr(40'hFFFFFFFFFF, 1'b1);
    send_word(32'hA5A5A5A5);
    send_word(32'h5A5A5A5A);
    drain("wb_q_drained_wrap");

    // Abort after 2 of 4 data bytes: no cycle, new address accepted.
    send_addr(40'h20, 1'b1);
    strobe(8'h11, 1'b0, 1'b1, 1);
    strobe(8'h22, 1'b0, 1'b1, 1);
    wb_q.push_back('{1'b1, 36'h30, 32'h01020304});
    send_addr(40'h30, 1'b1);
    send_word(32'h01020304);
    drain("wb_q_drained_abort");
    chk("abort_err", bus.wb_err_o, 0);

    // Event while nwait is low is dropped and flags an error.
    ws = 20;
    wb_q.push_back('{1'b1, 36'h40, 32'hCAFEF00D});
    send_addr(40'h40, 1'b1);
    send_word(32'hCAFEF00D);
    strobe(8'h99, 1'b0, 1'b1, 0);
    chk("violation_err", bus.wb_err_o, 1);
    ws = 0;
    wb_q.push_back('{1'b1, 36'h41, 32'h12345678});
    send_word(32'h12345678);
    drain("wb_q_drained_violation");
    chk("err_sticky", bus.wb_err_o, 1);
    send_addr(40'h50, 1'b1);
    chk("err_cleared_by_start", bus.wb_err_o, 0);

`ifdef LIMB_WB_TIMEOUT_EN
    // Slave never acks: 16 clk watchdog, all-ones data, address still moves.
    no_ack = 1;
    wb_q.push_back('{1'b0, 36'h60, 32'h0});
    wb_q.push_back('{1'b0, 36'h61, 32'h0});
    send_addr(40'h60, 1'b0);
    wait_nwait();
    chk("tmo_cyc_len", last_cyc_run, 16);
    chk("tmo_err", bus.wb_err_o, 1);
    for (int i = 0; i < 4; i++) read_byte(8'hFF);
    drain("wb_q_drained_tmo");
    chk("tmo_adr_inc", bus.wb_adr_o, 36'h62);
    no_ack = 0;
    send_addr(40'h70, 1'b1);
    chk("tmo_err_cleared", bus.wb_err_o, 0);
`endif

    repeat (10) @(posedge clk); #1;
    chk("wb_q_final", wb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
